reg_native_disp: RTL and testbench

REG_NATIVE_DISP -- requirements
Module: reg_native_disp

---
 rtl/reg_native_disp_pkg.sv | 22 ++
 rtl/reg_native_disp_timer.sv | 54 +++++
 rtl/reg_native_disp.sv | 233 +++++++++++++++++++++++
 tb/tb_reg_native_disp.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_native_disp_pkg.sv
// reg_native_disp_pkg
// Shared definitions for the reg_native dispatcher:
//   - state_e           : dispatcher FSM states
//   - RD_DATA_TIMEOUT   : read data returned on a downstream timeout (all ones)
//   - RD_DATA_DECERR    : read data returned on a decode error (zero)
//   - TMR_W             : width of the timeout counter
// The read-data constants are kept wide and sliced down to DATA_WIDTH by users.
package reg_native_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int unsigned       MAX_DW          = 1024;
  localparam logic [MAX_DW-1:0] RD_DATA_TIMEOUT = '1;
  localparam logic [MAX_DW-1:0] RD_DATA_DECERR  = '0;
  localparam int unsigned       TMR_W           = 16;

endpackage : reg_native_disp_pkg

// File: rtl/reg_native_disp_timer.sv
// reg_native_disp_timer
// Downstream ack timeout counter. Cleared when a request is forwarded,
// counts while the dispatcher waits, and flags expiry once the count
// reaches TIMEOUT_CYCLES. The count saturates at that value.
// Ports:
//   fsm_clk  (in)  clock
//   fsm_rstn (in)  synchronous active-low reset
//   clear    (in)  restart the count from zero
//   enable   (in)  advance the count by one
//   expired  (out) registered, high while count == TIMEOUT_CYCLES
module reg_native_disp_timer
  import reg_native_disp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic fsm_clk,
  input  logic fsm_rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;
  logic             expired_q;
  logic             expired_d;

  // Next count: clear wins, otherwise advance until the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired_q) begin
      cnt_d = cnt_q + TMR_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    expired_d = (cnt_d == TMR_W'(TIMEOUT_CYCLES));
  end

  // Counter and expiry flag registers.
  always_ff @(posedge fsm_clk) begin
    if (!fsm_rstn) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule : reg_native_disp_timer

// File: rtl/reg_native_disp.sv
// reg_native_disp
// Dispatches one outstanding reg_native_if request from regmst to one of
// FORWARD_NUM downstream regslv ports, each owning a 2^WIN_BITS byte window
// starting at BASE_ADDR, and returns the downstream response upstream.
// Optional feature: define REG_NATIVE_DISP_TIMEOUT_EN to abort a request
// after TIMEOUT_CYCLES wait cycles (rd_data all ones, err pulse).
// Ports:
//   fsm_clk, fsm_rstn            clock, synchronous active-low reset
//   req_vld, wr_en, rd_en,
//   addr, wr_data                upstream request
//   ack_vld, rd_data             upstream response (rd_data 0 unless ack_vld)
//   ds_req_vld, ds_wr_en,
//   ds_rd_en                     per-port downstream strobes (one FWD cycle)
//   ds_addr, ds_wr_data          shared downstream address/data
//   ds_ack_vld, ds_rd_data       per-port downstream response
//   err                          pulse with ack_vld on decode error/timeout
// All outputs are registered.
module reg_native_disp
  import reg_native_disp_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 64,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           FORWARD_NUM    = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned           WIN_BITS       = 12,
  parameter int unsigned           TIMEOUT_CYCLES = 255
) (
  input  logic                              fsm_clk,
  input  logic                              fsm_rstn,
  input  logic                              req_vld,
  input  logic                              wr_en,
  input  logic                              rd_en,
  input  logic [ADDR_WIDTH-1:0]             addr,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  output logic                              ack_vld,
  output logic [DATA_WIDTH-1:0]             rd_data,
  output logic [FORWARD_NUM-1:0]            ds_req_vld,
  output logic [FORWARD_NUM-1:0]            ds_wr_en,
  output logic [FORWARD_NUM-1:0]            ds_rd_en,
  output logic [ADDR_WIDTH-1:0]             ds_addr,
  output logic [DATA_WIDTH-1:0]             ds_wr_data,
  input  logic [FORWARD_NUM-1:0]            ds_ack_vld,
  input  logic [FORWARD_NUM*DATA_WIDTH-1:0] ds_rd_data,
  output logic                              err
);

  localparam int unsigned IDX_W = (FORWARD_NUM > 1) ? $clog2(FORWARD_NUM) : 1;
  localparam logic [ADDR_WIDTH-1:0] WIN_MASK =
    (ADDR_WIDTH'(1) << WIN_BITS) - ADDR_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    wr_q, wr_d;
  logic                    ack_vld_q, ack_vld_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    err_q, err_d;
  logic [FORWARD_NUM-1:0]  ds_req_vld_q, ds_req_vld_d;
  logic [FORWARD_NUM-1:0]  ds_wr_en_q, ds_wr_en_d;
  logic [FORWARD_NUM-1:0]  ds_rd_en_q, ds_rd_en_d;
  logic [ADDR_WIDTH-1:0]   ds_addr_q, ds_addr_d;
  logic [DATA_WIDTH-1:0]   ds_wr_data_q, ds_wr_data_d;

  logic [ADDR_WIDTH-1:0]   offset_s;
  logic [ADDR_WIDTH-1:0]   idx_full_s;
  logic [IDX_W-1:0]        idx_s;
  logic                    dec_err_s;
  logic                    rd_s;
  logic                    ack_sel_s;
  logic [DATA_WIDTH-1:0]   ack_data_s;
  logic                    timeout_s;

  // Address decode; the whole offset above the window is the port index,
  // so anything beyond FORWARD_NUM windows is a decode error.
  assign offset_s   = addr - BASE_ADDR;
  assign idx_full_s = offset_s >> WIN_BITS;
  assign idx_s      = idx_full_s[IDX_W-1:0];
  assign dec_err_s  = (addr < BASE_ADDR) ||
                      (idx_full_s >= ADDR_WIDTH'(FORWARD_NUM));
  // A request with neither strobe set is a read.
  assign rd_s       = rd_en | ~wr_en;

  // Only the addressed port's ack is observed.
  assign ack_sel_s  = ds_ack_vld[idx_q];
  assign ack_data_s = ds_rd_data[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];

`ifdef REG_NATIVE_DISP_TIMEOUT_EN
  logic tmr_clear_s;
  logic tmr_en_s;
  logic tmr_expired_s;

  assign tmr_clear_s = (state_q == ST_IDLE) && req_vld && !dec_err_s;
  assign tmr_en_s    = (state_q == ST_WAIT);
  assign timeout_s   = (state_q == ST_WAIT) && tmr_expired_s;

  reg_native_disp_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .fsm_clk  (fsm_clk),
    .fsm_rstn (fsm_rstn),
    .clear    (tmr_clear_s),
    .enable   (tmr_en_s),
    .expired  (tmr_expired_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge fsm_clk) begin
    if (!fsm_rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_vld) begin
          state_d = dec_err_s ? ST_RESP : ST_FWD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FWD: begin
        if (ack_sel_s) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ack_sel_s || timeout_s) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/next-register logic. Outputs are computed one cycle ahead and
  // registered, so strobes land in FWD and the response lands in RESP.
  always_comb begin
    idx_d        = idx_q;
    wr_d         = wr_q;
    ack_vld_d    = 1'b0;
    rd_data_d    = '0;
    err_d        = 1'b0;
    ds_req_vld_d = '0;
    ds_wr_en_d   = '0;
    ds_rd_en_d   = '0;
    ds_addr_d    = ds_addr_q;
    ds_wr_data_d = ds_wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (req_vld) begin
          wr_d = wr_en;
          if (dec_err_s) begin
            ack_vld_d = 1'b1;
            err_d     = 1'b1;
            rd_data_d = RD_DATA_DECERR[DATA_WIDTH-1:0];
          end else begin
            idx_d               = idx_s;
            ds_req_vld_d[idx_s] = 1'b1;
            ds_wr_en_d[idx_s]   = wr_en;
            ds_rd_en_d[idx_s]   = rd_s;
            ds_addr_d           = offset_s & WIN_MASK;
            ds_wr_data_d        = wr_data;
          end
        end else begin
          wr_d = wr_q;
        end
      end
      ST_FWD, ST_WAIT: begin
        if (ack_sel_s) begin
          ack_vld_d = 1'b1;
          rd_data_d = wr_q ? '0 : ack_data_s;
        end else if (timeout_s) begin
          ack_vld_d = 1'b1;
          err_d     = 1'b1;
          rd_data_d = RD_DATA_TIMEOUT[DATA_WIDTH-1:0];
        end else begin
          ack_vld_d = 1'b0;
        end
      end
      ST_RESP: ack_vld_d = 1'b0;
      default: ack_vld_d = 1'b0;
    endcase
  end

  // Output and transaction context registers.
  always_ff @(posedge fsm_clk) begin
    if (!fsm_rstn) begin
      idx_q        <= '0;
      wr_q         <= 1'b0;
      ack_vld_q    <= 1'b0;
      rd_data_q    <= '0;
      err_q        <= 1'b0;
      ds_req_vld_q <= '0;
      ds_wr_en_q   <= '0;
      ds_rd_en_q   <= '0;
      ds_addr_q    <= '0;
      ds_wr_data_q <= '0;
    end else begin
      idx_q        <= idx_d;
      wr_q         <= wr_d;
      ack_vld_q    <= ack_vld_d;
      rd_data_q    <= rd_data_d;
      err_q        <= err_d;
      ds_req_vld_q <= ds_req_vld_d;
      ds_wr_en_q   <= ds_wr_en_d;
      ds_rd_en_q   <= ds_rd_en_d;
      ds_addr_q    <= ds_addr_d;
      ds_wr_data_q <= ds_wr_data_d;
    end
  end

  assign ack_vld    = ack_vld_q;
  assign rd_data    = rd_data_q;
  assign err        = err_q;
  assign ds_req_vld = ds_req_vld_q;
  assign ds_wr_en   = ds_wr_en_q;
  assign ds_rd_en   = ds_rd_en_q;
  assign ds_addr    = ds_addr_q;
  assign ds_wr_data = ds_wr_data_q;

endmodule : reg_native_disp

// File: tb/tb_reg_native_disp.sv
// Directed self-checking bench for reg_native_disp (FORWARD_NUM=4,
// WIN_BITS=12, BASE_ADDR=0, TIMEOUT_CYCLES=8). The timeout scenario
// adapts to whether REG_NATIVE_DISP_TIMEOUT_EN is defined.
module tb_reg_native_disp;

  localparam int AW = 64;
  localparam int DW = 32;
  localparam int FN = 4;

  logic            fsm_clk = 1'b0;
  logic            fsm_rstn;
  logic            req_vld, wr_en, rd_en;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wr_data;
  logic            ack_vld;
  logic [DW-1:0]   rd_data;
  logic [FN-1:0]   ds_req_vld, ds_wr_en, ds_rd_en;
  logic [AW-1:0]   ds_addr;
  logic [DW-1:0]   ds_wr_data;
  logic [FN-1:0]   ds_ack_vld;
  logic [FN*DW-1:0] ds_rd_data;
  logic            err;

  int total = 0;
  int bad   = 0;
  int ack_cnt = 0;
  int ack_snap;

  reg_native_disp #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .FORWARD_NUM    (FN),
    .BASE_ADDR      (64'h0),
    .WIN_BITS       (12),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .fsm_clk    (fsm_clk),
    .fsm_rstn   (fsm_rstn),
    .req_vld    (req_vld),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .addr       (addr),
    .wr_data    (wr_data),
    .ack_vld    (ack_vld),
    .rd_data    (rd_data),
    .ds_req_vld (ds_req_vld),
    .ds_wr_en   (ds_wr_en),
    .ds_rd_en   (ds_rd_en),
    .ds_addr    (ds_addr),
    .ds_wr_data (ds_wr_data),
    .ds_ack_vld (ds_ack_vld),
    .ds_rd_data (ds_rd_data),
    .err        (err)
  );

  always #5 fsm_clk = ~fsm_clk;

  // Count every upstream ack pulse, sampled mid-cycle.
  always @(negedge fsm_clk) if (ack_vld === 1'b1) ack_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges, landing 1 time unit after the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge fsm_clk);
      #1;
    end
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic w, input logic r, input logic [DW-1:0] d);
    req_vld = 1'b1; addr = a; wr_en = w; rd_en = r; wr_data = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 64'(ack_vld), 64'h0);
    chk({tag, "_rdata"}, 64'(rd_data), 64'h0);
    chk({tag, "_err"}, 64'(err), 64'h0);
    chk({tag, "_dsreq"}, 64'({ds_req_vld, ds_wr_en, ds_rd_en}), 64'h0);
    chk({tag, "_dsaddr"}, ds_addr, 64'h0);
    chk({tag, "_dswdata"}, 64'(ds_wr_data), 64'h0);
  endtask

  initial begin
    fsm_rstn = 1'b0; req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    addr = '0; wr_data = '0; ds_ack_vld = '0; ds_rd_data = '0;
    tick(3);
    chk_all_zero("reset");
    fsm_rstn = 1'b1;
    tick(1);

    // Read 0x1004 -> port 1, ack after 3 cycles.
    issue(64'h1004, 1'b0, 1'b1, 32'h0);
    tick(1);
    req_vld = 1'b0;
    chk("rd_dsreq", 64'(ds_req_vld), 64'h2);
    chk("rd_dsrden", 64'(ds_rd_en), 64'h2);
    chk("rd_dswren", 64'(ds_wr_en), 64'h0);
    chk("rd_dsaddr", ds_addr, 64'h4);
    tick(1);
    chk("rd_dsreq_once", 64'(ds_req_vld), 64'h0);
    chk("rd_dsaddr_hold", ds_addr, 64'h4);
    tick(1);
    ds_ack_vld = 4'b0010; ds_rd_data[63:32] = 32'h12345678;
    chk("rd_noack_yet", 64'(ack_vld), 64'h0);
    tick(1);
    ds_ack_vld = '0;
    chk("rd_ack", 64'(ack_vld), 64'h1);
    chk("rd_data", 64'(rd_data), 64'h12345678);
    chk("rd_err", 64'(err), 64'h0);
    tick(1);
    chk("rd_ack_one", 64'(ack_vld), 64'h0);
    chk("rd_data_zero", 64'(rd_data), 64'h0);

    // Write 0xCAFEF00D to 0x3010 -> port 3, ack in the FWD cycle.
    issue(64'h3010, 1'b1, 1'b0, 32'hCAFEF00D);
    tick(1);
    req_vld = 1'b0;
    chk("wr_dsreq", 64'(ds_req_vld), 64'h8);
    chk("wr_dswren", 64'(ds_wr_en), 64'h8);
    chk("wr_dsrden", 64'(ds_rd_en), 64'h0);
    chk("wr_dswdata", 64'(ds_wr_data), 64'hCAFEF00D);
    chk("wr_dsaddr", ds_addr, 64'h10);
    ds_ack_vld = 4'b1000; ds_rd_data[127:96] = 32'hDEADBEEF;
    tick(1);
    ds_ack_vld = '0;
    chk("wr_ack", 64'(ack_vld), 64'h1);
    chk("wr_rdata", 64'(rd_data), 64'h0);
    chk("wr_err", 64'(err), 64'h0);
    tick(1);

    // Decode error at 0x5000.
    issue(64'h5000, 1'b0, 1'b1, 32'h0);
    tick(1);
    req_vld = 1'b0;
    chk("dec_ack", 64'(ack_vld), 64'h1);
    chk("dec_err", 64'(err), 64'h1);
    chk("dec_rdata", 64'(rd_data), 64'h0);
    chk("dec_dsreq", 64'(ds_req_vld), 64'h0);
    tick(1);
    chk("dec_err_pulse", 64'(err), 64'h0);
    chk("dec_ack_pulse", 64'(ack_vld), 64'h0);

    // Port 1 addressed, port 0 acks (ignored), stray req_vld ignored.
    ack_snap = ack_cnt;
    issue(64'h1100, 1'b0, 1'b1, 32'h0);
    tick(1);
    issue(64'h5000, 1'b0, 1'b1, 32'h0);
    ds_ack_vld = 4'b0001; ds_rd_data[31:0] = 32'h11111111;
    tick(2);
    req_vld = 1'b0;
    chk("wrongport_noack", 64'(ack_vld), 64'h0);
    chk("busy_req_noerr", 64'(err), 64'h0);
    ds_ack_vld = 4'b0010; ds_rd_data[63:32] = 32'hA5A5A5A5;
    tick(1);
    ds_ack_vld = '0;
    chk("rightport_ack", 64'(ack_vld), 64'h1);
    chk("rightport_data", 64'(rd_data), 64'hA5A5A5A5);
    tick(2);
    chk("rightport_one_ack", 64'(ack_cnt - ack_snap), 64'h1);

    // Port 2 never acks.
    issue(64'h2000, 1'b0, 1'b1, 32'h0);
    tick(1);
    req_vld = 1'b0;
    chk("to_dsreq", 64'(ds_req_vld), 64'h4);
    ack_snap = ack_cnt;
    for (int i = 0; i < 30 && ack_vld !== 1'b1; i++) tick(1);
`ifdef REG_NATIVE_DISP_TIMEOUT_EN
    chk("to_ack", 64'(ack_vld), 64'h1);
    chk("to_rdata", 64'(rd_data), 64'hFFFFFFFF);
    chk("to_err", 64'(err), 64'h1);
    tick(2);
    ds_ack_vld = 4'b0100; ds_rd_data[95:64] = 32'h22222222;
    tick(1);
    ds_ack_vld = '0;
    tick(3);
    chk("to_late_ack_ignored", 64'(ack_cnt - ack_snap), 64'h1);
`else
    chk("wait_forever_noack", 64'(ack_vld), 64'h0);
    ds_ack_vld = 4'b0100; ds_rd_data[95:64] = 32'h22222222;
    tick(1);
    ds_ack_vld = '0;
    chk("wait_late_ack", 64'(ack_vld), 64'h1);
    chk("wait_late_data", 64'(rd_data), 64'h22222222);
    chk("wait_late_noerr", 64'(err), 64'h0);
    tick(1);
`endif

    // Reset during WAIT, then a late ack in IDLE, then a normal request.
    issue(64'h0008, 1'b0, 1'b1, 32'h0);
    tick(1);
    req_vld = 1'b0;
    tick(1);
    fsm_rstn = 1'b0;
    tick(1);
    chk_all_zero("midrst");
    fsm_rstn = 1'b1;
    ack_snap = ack_cnt;
    ds_ack_vld = 4'b0001; ds_rd_data[31:0] = 32'h33333333;
    tick(2);
    ds_ack_vld = '0;
    tick(1);
    chk("midrst_noack", 64'(ack_cnt - ack_snap), 64'h0);
    issue(64'h0010, 1'b0, 1'b0, 32'h0);
    tick(1);
    req_vld = 1'b0;
    chk("post_rst_dsreq", 64'(ds_req_vld), 64'h1);
    chk("noflag_is_read", 64'(ds_rd_en), 64'h1);
    chk("post_rst_dsaddr", ds_addr, 64'h10);
    ds_ack_vld = 4'b0001; ds_rd_data[31:0] = 32'h0BADF00D;
    tick(1);
    ds_ack_vld = '0;
    chk("post_rst_ack", 64'(ack_vld), 64'h1);
    chk("post_rst_data", 64'(rd_data), 64'h0BADF00D);
    tick(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_reg_native_disp
